// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one recode/add/shift step per clock, start/done handshake.
// Optional macro BOOTH_OPCOUNT_EN adds op_count, the number of steps that added or subtracted.
module booth_seq_mult #(
    parameter int unsigned WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           multiplicand,
    input  logic [WIDTH-1:0]           multiplier,
    output logic                       busy,
    output logic                       done,
    output logic [2*WIDTH-1:0]         product
`ifdef BOOTH_OPCOUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] op_count
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH:0]     sum;
    logic               accept;
    logic               op_step;
`ifdef BOOTH_OPCOUNT_EN
    logic [CntW-1:0]    opc_q, opc_d;
`endif

    // busy_q is still high in the done cycle, so a start there is ignored.
    assign accept = (state_q == StIdle) && start && !busy_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        sum       = a_q;
        op_step   = 1'b0;
`ifdef BOOTH_OPCOUNT_EN
        opc_d     = opc_q;
`endif

        unique case (state_q)
            StIdle: begin
                busy_d = accept;
                if (accept) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    q1_d    = 1'b0;
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    cnt_d   = CntW'(WIDTH);
                    state_d = StCalc;
`ifdef BOOTH_OPCOUNT_EN
                    opc_d   = '0;
`endif
                end
            end
            StCalc: begin
                case ({q_q[0], q1_q})
                    2'b01: begin
                        sum     = a_q + m_q;
                        op_step = 1'b1;
                    end
                    2'b10: begin
                        sum     = a_q - m_q;
                        op_step = 1'b1;
                    end
                    default: sum = a_q;
                endcase
                // Arithmetic shift of {A, Q, q_1}, replicating A's sign bit.
                a_d   = {sum[WIDTH], sum[WIDTH:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = StDone;
                end
`ifdef BOOTH_OPCOUNT_EN
                if (op_step) begin
                    opc_d = opc_q + 1'b1;
                end
`endif
            end
            StDone: begin
                product_d = {a_q[WIDTH-1:0], q_q};
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef BOOTH_OPCOUNT_EN
            opc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
`ifdef BOOTH_OPCOUNT_EN
            opc_q     <= opc_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
`ifdef BOOTH_OPCOUNT_EN
    assign op_count = opc_q;
`endif

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed + random bench for booth_seq_mult at WIDTH 3, 4 and 8 against plain signed arithmetic.
// Honours BOOTH_OPCOUNT_EN when defined.
module tb_booth_seq_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start3 = 1'b0, start4 = 1'b0, start8 = 1'b0;
    logic [2:0] m3 = '0, q3 = '0;
    logic [3:0] m4 = '0, q4 = '0;
    logic [7:0] m8 = '0, q8 = '0;
    logic       busy3, busy4, busy8, done3, done4, done8;
    logic [5:0]  p3;
    logic [7:0]  p4;
    logic [15:0] p8;
`ifdef BOOTH_OPCOUNT_EN
    logic [1:0] oc3;
    logic [2:0] oc4;
    logic [3:0] oc8;
`endif

    booth_seq_mult #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .multiplicand(m3), .multiplier(q3),
        .busy(busy3), .done(done3), .product(p3)
`ifdef BOOTH_OPCOUNT_EN
        , .op_count(oc3)
`endif
    );
    booth_seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .multiplicand(m4), .multiplier(q4),
        .busy(busy4), .done(done4), .product(p4)
`ifdef BOOTH_OPCOUNT_EN
        , .op_count(oc4)
`endif
    );
    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .multiplicand(m8), .multiplier(q8),
        .busy(busy8), .done(done8), .product(p8)
`ifdef BOOTH_OPCOUNT_EN
        , .op_count(oc8)
`endif
    );

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic s, input int m, input int q);
        case (w)
            3: begin start3 = s; m3 = 3'(m); q3 = 3'(q); end
            4: begin start4 = s; m4 = 4'(m); q4 = 4'(q); end
            default: begin start8 = s; m8 = 8'(m); q8 = 8'(q); end
        endcase
    endtask

    function automatic logic done_of(input int w);
        case (w)
            3: return done3;
            4: return done4;
            default: return done8;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            3: return busy3;
            4: return busy4;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [63:0] prod_of(input int w);
        case (w)
            3: return 64'(p3);
            4: return 64'(p4);
            default: return 64'(p8);
        endcase
    endfunction

    // Reference product, truncated to 2*w bits.
    function automatic logic [63:0] ref_prod(input int w, input int m, input int q);
        longint p;
        p = longint'(m) * longint'(q);
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic int rnd_s(input int w);
        int v;
        v = int'($urandom_range(0, 32'((1 << w) - 1)));
        if (v >= (1 << (w - 1))) v -= (1 << w);
        return v;
    endfunction

`ifdef BOOTH_OPCOUNT_EN
    function automatic logic [63:0] oc_of(input int w);
        case (w)
            3: return 64'(oc3);
            4: return 64'(oc4);
            default: return 64'(oc8);
        endcase
    endfunction

    // Adds/subtracts happen where adjacent multiplier bits differ (with an implicit 0 below bit 0).
    function automatic int ref_ops(input int w, input int q);
        int n = 0;
        int prev = 0;
        for (int i = 0; i < w; i++) begin
            if (((q >> i) & 1) != prev) n++;
            prev = (q >> i) & 1;
        end
        return n;
    endfunction
`endif

    task automatic run_op(input int w, input int m, input int q);
        int n;
        logic [63:0] exp;
        exp = ref_prod(w, m, q);
        @(negedge clk);
        set_in(w, 1'b1, m, q);
        @(posedge clk);
        #1;
        set_in(w, 1'b0, int'($urandom), int'($urandom));
        chk("busy_after_start", 64'(busy_of(w)), 64'd1);
        chk("no_early_done", 64'(done_of(w)), 64'd0);
        n = 0;
        while (!done_of(w) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(w + 1));
        chk("product", prod_of(w), exp);
`ifdef BOOTH_OPCOUNT_EN
        chk("op_count", oc_of(w), 64'(ref_ops(w, q)));
`endif
        @(posedge clk);
        #1;
        chk("done_single", 64'(done_of(w)), 64'd0);
        chk("busy_clear", 64'(busy_of(w)), 64'd0);
        chk("product_hold", prod_of(w), exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ndone;
        logic [63:0] got;

        #2;
        chk("rst_busy", 64'(busy3), 64'd0);
        chk("rst_done", 64'(done3), 64'd0);
        chk("rst_product3", 64'(p3), 64'd0);
        chk("rst_product8", 64'(p8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases from the test plan.
        run_op(3, 3, -2);
        run_op(3, -4, -4);
        run_op(3, -4, 3);
        run_op(3, 0, -1);
        run_op(8, -128, -128);
        run_op(3, -4, -1);
        run_op(8, 127, -128);

        // Start during CALC and during the done cycle must both be ignored.
        got = '0;
        ndone = 0;
        @(negedge clk);
        set_in(3, 1'b1, 3, -2);
        @(posedge clk);
        #1;
        set_in(3, 1'b0, -4, -4);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            start3 = (i == 1);
            if (done3) begin
                ndone++;
                got = 64'(p3);
                start3 = 1'b1;
            end
        end
        start3 = 1'b0;
        chk("ignored_start_done_count", 64'(ndone), 64'd1);
        chk("ignored_start_product", got, ref_prod(3, 3, -2));
        chk("ignored_start_idle", 64'(busy3), 64'd0);

        // Reset mid-CALC aborts and clears outputs.
        @(negedge clk);
        set_in(3, 1'b1, 2, 3);
        @(posedge clk);
        #1;
        set_in(3, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy3), 64'd0);
        chk("abort_done", 64'(done3), 64'd0);
        chk("abort_product", 64'(p3), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done3) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op(3, -4, 3);

        // Exhaustive WIDTH=4.
        for (int m = -8; m < 8; m++) begin
            for (int q = -8; q < 8; q++) begin
                run_op(4, m, q);
            end
        end

        // Random WIDTH=3 and WIDTH=8.
        for (int i = 0; i < 30; i++) begin
            run_op(3, rnd_s(3), rnd_s(3));
            run_op(8, rnd_s(8), rnd_s(8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
